// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM channel path (demux and mux).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef logic [SLOT_W-1:0] slot_t;

    // Slot whose acceptance completes a frame
    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: clear to 0, load to 1 on a frame start, else advance mod 4.
// Latency: new slot value visible the cycle after the control input.
// Backpressure: none; the caller only asserts inc on accepted samples.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t slot
);

    // Priority: clear beats load, load beats increment; natural wrap from 3 to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= slot_t'(1);
        end else if (inc) begin
            slot <= slot + slot_t'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: rebuilds ch0..ch3 words from a slot-interleaved stream.
// Latency: frame word and out_valid appear on the edge accepting the slot-3 sample.
// Backpressure: none; accepts one sample per cycle, in_valid gaps allowed. Optional
// strict framing check with TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_sof,
    output logic [NUM_SLOTS*WIDTH-1:0]   out_data,
    output logic                         out_valid,
    output logic [SLOT_W-1:0]            out_slot,
    output logic                         locked,
    output logic                         sync_err
);

    state_t         state;
    state_t         state_nxt;
    slot_t          slot;

    logic           sh_wr;
    slot_t          sh_idx;
    logic           emit;
    logic           ctr_clr;
    logic           ctr_load1;
    logic           ctr_inc;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic           sof_misalign;
    logic           missing_sof;
`endif

    // Slots 0..2 are parked here; slot 3 goes straight from in_data to out_data
    logic [WIDTH-1:0] shadow [0:NUM_SLOTS-2];

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: HUNT waits for a marked sample; LOCK only falls back on a missing marker
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (in_valid && in_sof) begin
                    state_nxt = LOCK;
                end
            end
            default: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                if (missing_sof) begin
                    state_nxt = HUNT;
                end
`endif
            end
        endcase
    end

    // Per-sample datapath control decoded from state, slot and the input flags
    always_comb begin
        sh_wr     = 1'b0;
        sh_idx    = slot;
        emit      = 1'b0;
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        sof_misalign = 1'b0;
        missing_sof  = 1'b0;
`endif
        if (in_valid) begin
            if (in_sof) begin
                // Any marked sample restarts the frame at slot 0; a partial frame is dropped
                sh_wr     = 1'b1;
                sh_idx    = '0;
                ctr_load1 = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                sof_misalign = (state == LOCK) && (slot != '0);
`endif
            end else if (state == LOCK) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                if (slot == '0) begin
                    missing_sof = 1'b1;
                    ctr_clr     = 1'b1;
                end else
`endif
                if (slot == LAST_SLOT) begin
                    emit    = 1'b1;
                    ctr_inc = 1'b1;
                end else begin
                    sh_wr   = 1'b1;
                    ctr_inc = 1'b1;
                end
            end
        end
    end

    // Shadow capture of slots 0..2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if (sh_wr && (sh_idx == slot_t'(i))) begin
                    shadow[i] <= in_data;
                end
            end
        end
    end

    // Frame output register: whole word updated at once, held until the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_data <= {in_data, shadow[2], shadow[1], shadow[0]};
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // One-cycle framing error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= sof_misalign | missing_sof;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

    assign out_slot = slot;
    assign locked   = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    localparam int WIDTH = 8;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  out_slot;
    logic        locked;
    logic        sync_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          pulse_cyc[$];

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_slot  (out_slot),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every out_valid pops one expected frame word
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) err_cnt++;
            if (out_valid) begin
                valid_cnt++;
                pulse_cyc.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: out_valid with out_data=%h, no frame expected", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        miscompares++;
                        $display("FAIL sb_frame: out_data=%h expected %h", out_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one sample for one cycle; returns at the following negedge
    task automatic send(input logic [7:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        idle(0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        int budget;
        budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d expected frames never produced, expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_slot !== 2'd0) begin miscompares++; $display("FAIL reset_out_slot: got %0d expected 0", out_slot); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_q.push_back(32'h44332211);
        send(8'h11, 1'b1);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL basic_lock: locked=%b expected 1", locked); end
        vectors++; if (out_slot !== 2'd1) begin miscompares++; $display("FAIL basic_slot1: out_slot=%0d expected 1", out_slot); end
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: out_valid=%b expected 0", out_valid); end
        send(8'h44, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: out_valid=%b expected 1", out_valid); end
        vectors++; if (out_data !== 32'h44332211) begin miscompares++; $display("FAIL basic_data: out_data=%h expected 44332211", out_data); end
        vectors++; if (out_slot !== 2'd0) begin miscompares++; $display("FAIL basic_wrap: out_slot=%0d expected 0", out_slot); end
        idle(1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: out_valid=%b expected 0", out_valid); end
        vectors++; if (out_data !== 32'h44332211) begin miscompares++; $display("FAIL basic_hold: out_data=%h expected 44332211", out_data); end
        check_drained("basic");
    endtask

    task automatic test_no_sof();
        int v0;
        do_reset();
        v0 = valid_cnt;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idle(3);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL nosof_locked: locked=%b expected 0", locked); end
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL nosof_data: out_data=%h expected 0", out_data); end
        vectors++; if (out_slot !== 2'd0) begin miscompares++; $display("FAIL nosof_slot: out_slot=%0d expected 0", out_slot); end
        vectors++; if (valid_cnt !== v0) begin miscompares++; $display("FAIL nosof_valid: %0d pulses expected 0", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [31:0] frame;
        logic [7:0]  d;
        p0 = pulse_cyc.size();
        for (int f = 0; f < 3; f++) begin
            frame = '0;
            for (int s = 0; s < 4; s++) begin
                d = 8'(16 * (f + 1) + s + 3);
                frame[8*s +: 8] = d;
                if (s == 3) exp_q.push_back(frame);
                send(d, (s == 0));
            end
        end
        idle(3);
        vectors++;
        if (pulse_cyc.size() - p0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: %0d pulses expected 3", pulse_cyc.size() - p0);
        end else begin
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (pulse_cyc[p0 + k] - pulse_cyc[p0 + k - 1] !== 4) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: pulse gap %0d cycles expected 4", pulse_cyc[p0 + k] - pulse_cyc[p0 + k - 1]);
                end
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_gaps();
        int v0;
        v0 = valid_cnt;
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        idle(3);
        send(8'h77, 1'b0);
        idle(1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early: out_valid=%b expected 0", out_valid); end
        exp_q.push_back(32'h88776655);
        send(8'h88, 1'b0);
        idle(3);
        vectors++; if (out_data !== 32'h88776655) begin miscompares++; $display("FAIL gaps_data: out_data=%h expected 88776655", out_data); end
        vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL gaps_count: %0d pulses expected 1", valid_cnt - v0); end
        check_drained("gaps");
    endtask

    task automatic test_misalign();
        int e0;
        int v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        exp_q.push_back(32'h40302010);
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h10, 1'b1);
        vectors++; if (sync_err !== CHK) begin miscompares++; $display("FAIL misalign_err: sync_err=%b expected %b", sync_err, CHK); end
        vectors++; if (out_slot !== 2'd1) begin miscompares++; $display("FAIL misalign_slot: out_slot=%0d expected 1", out_slot); end
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        idle(3);
        vectors++; if (out_data !== 32'h40302010) begin miscompares++; $display("FAIL misalign_data: out_data=%h expected 40302010", out_data); end
        vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL misalign_count: %0d pulses expected 1", valid_cnt - v0); end
        vectors++; if (err_cnt - e0 !== int'(CHK)) begin miscompares++; $display("FAIL misalign_errcnt: %0d pulses expected %0d", err_cnt - e0, int'(CHK)); end
        check_drained("misalign");
    endtask

    task automatic test_flywheel();
        int v0;
        v0 = valid_cnt;
        if (!CHK) exp_q.push_back(32'h94939291);
        send(8'h91, 1'b0);
        vectors++; if (sync_err !== CHK) begin miscompares++; $display("FAIL fly_err: sync_err=%b expected %b", sync_err, CHK); end
        vectors++; if (locked !== !CHK) begin miscompares++; $display("FAIL fly_locked: locked=%b expected %b", locked, !CHK); end
        send(8'h92, 1'b0);
        send(8'h93, 1'b0);
        send(8'h94, 1'b0);
        idle(3);
        vectors++; if (valid_cnt - v0 !== int'(!CHK)) begin miscompares++; $display("FAIL fly_count: %0d pulses expected %0d", valid_cnt - v0, int'(!CHK)); end
        vectors++;
        if (out_data !== (CHK ? 32'h40302010 : 32'h94939291)) begin
            miscompares++;
            $display("FAIL fly_data: out_data=%h expected %h", out_data, (CHK ? 32'h40302010 : 32'h94939291));
        end
        check_drained("fly");
    endtask

    task automatic test_reset_midframe();
        if (CHK) begin
            send(8'hE0, 1'b1);
            idle(1);
        end
        send(8'hE1, 1'b1);
        send(8'hE2, 1'b0);
        vectors++; if (out_slot !== 2'd2) begin miscompares++; $display("FAIL rstmid_slot: out_slot=%0d expected 2", out_slot); end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        #1;
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: out_data=%h expected 0", out_data); end
        vectors++; if (out_slot !== 2'd0) begin miscompares++; $display("FAIL rstmid_slot0: out_slot=%0d expected 0", out_slot); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_locked: locked=%b expected 0", locked); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: out_valid=%b expected 0", out_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'hA5, 1'b0);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_nosof: locked=%b expected 0", locked); end
        exp_q.push_back(32'h0D0C0BE3);
        send(8'hE3, 1'b1);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        send(8'h0D, 1'b0);
        idle(2);
        vectors++; if (out_data !== 32'h0D0C0BE3) begin miscompares++; $display("FAIL rstmid_frame: out_data=%h expected 0d0c0be3", out_data); end
        check_drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_sof();
        test_back_to_back();
        test_gaps();
        test_misalign();
        test_flywheel();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
